// File: rtl/ftq.sv
// Fetch target queue: in-order circular buffer of predicted fetch blocks from the BPU to the IFU.
// Pointers carry an extra wrap bit so that full and empty stay distinct with no separate counter.
module ftq #(
    parameter int XLEN            = 32,
    parameter int DEPTH           = 8,
    parameter int INSTR_PER_FETCH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               enq_valid_i,
    output logic                               enq_ready_o,
    input  logic [XLEN-1:0]                    enq_pc_i,
    input  logic [XLEN-1:0]                    enq_npc_i,
    input  logic                               enq_slot_valid_i,
    input  logic [$clog2(INSTR_PER_FETCH)-1:0] enq_slot_idx_i,
    input  logic [XLEN-1:0]                    enq_slot_target_i,
    output logic                               deq_valid_o,
    input  logic                               deq_ready_i,
    output logic [XLEN-1:0]                    deq_pc_o,
    output logic [XLEN-1:0]                    deq_npc_o,
    output logic                               deq_slot_valid_o,
    output logic [$clog2(INSTR_PER_FETCH)-1:0] deq_slot_idx_o,
    output logic [XLEN-1:0]                    deq_slot_target_o,
    output logic [$clog2(DEPTH)-1:0]           deq_ftq_idx_o,
    output logic [$clog2(DEPTH):0]             count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(INSTR_PER_FETCH);

    logic [XLEN-1:0] pc_q     [DEPTH];
    logic [XLEN-1:0] npc_q    [DEPTH];
    logic            sv_q     [DEPTH];
    logic [SW-1:0]   sidx_q   [DEPTH];
    logic [XLEN-1:0] stgt_q   [DEPTH];

    logic [AW:0] enq_ptr_q, enq_ptr_d;
    logic [AW:0] deq_ptr_q, deq_ptr_d;
    logic        empty, full, enq_fire, deq_fire;
    logic [AW-1:0] enq_idx, deq_idx;

    assign enq_idx  = enq_ptr_q[AW-1:0];
    assign deq_idx  = deq_ptr_q[AW-1:0];
    assign empty    = (enq_ptr_q == deq_ptr_q);
    assign full     = (enq_idx == deq_idx) && (enq_ptr_q[AW] != deq_ptr_q[AW]);

    // Ready/valid are independent of the partner handshake, so no enq->deq comb path exists.
    assign enq_ready_o = !full && !flush_i;
    assign deq_valid_o = !empty && !flush_i;
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign deq_fire    = deq_valid_o && deq_ready_i;

    always_comb begin
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        if (flush_i) begin
            enq_ptr_d = '0;
            deq_ptr_d = '0;
        end else begin
            if (enq_fire) enq_ptr_d = enq_ptr_q + 1'b1;
            if (deq_fire) deq_ptr_d = deq_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            pc_q[enq_idx]   <= enq_pc_i;
            npc_q[enq_idx]  <= enq_npc_i;
            sv_q[enq_idx]   <= enq_slot_valid_i;
            sidx_q[enq_idx] <= enq_slot_idx_i;
            stgt_q[enq_idx] <= enq_slot_target_i;
        end
    end

    // Head fields read as zero while empty, hiding uninitialised storage after reset.
    assign deq_pc_o          = empty ? '0 : pc_q[deq_idx];
    assign deq_npc_o         = empty ? '0 : npc_q[deq_idx];
    assign deq_slot_valid_o  = empty ? 1'b0 : sv_q[deq_idx];
    assign deq_slot_idx_o    = empty ? '0 : sidx_q[deq_idx];
    assign deq_slot_target_o = empty ? '0 : stgt_q[deq_idx];
    assign deq_ftq_idx_o     = deq_idx;
    assign count_o           = enq_ptr_q - deq_ptr_q;

    a_enq_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (enq_valid_i && !enq_ready_o && !flush_i) |=>
        (enq_valid_i && $stable(enq_pc_i) && $stable(enq_npc_i) && $stable(enq_slot_valid_i)
         && $stable(enq_slot_idx_i) && $stable(enq_slot_target_i)));

    a_ptr_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !$isunknown({enq_ptr_q, deq_ptr_q}));

endmodule

// File: tb/tb_ftq.sv
// Directed bench for ftq: a vector table for fill/full/flush sequences plus hand-written
// streaming, taken-slot stall and mid-stall reset sequences.
module tb_ftq;
    localparam int XLEN = 32;
    localparam int DEPTH = 8;
    localparam int IPF = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic            enq_valid_i;
    logic            enq_ready_o;
    logic [XLEN-1:0] enq_pc_i, enq_npc_i, enq_slot_target_i;
    logic            enq_slot_valid_i;
    logic [1:0]      enq_slot_idx_i;
    logic            deq_valid_o;
    logic            deq_ready_i;
    logic [XLEN-1:0] deq_pc_o, deq_npc_o, deq_slot_target_o;
    logic            deq_slot_valid_o;
    logic [1:0]      deq_slot_idx_o;
    logic [2:0]      deq_ftq_idx_o;
    logic [3:0]      count_o;

    ftq #(.XLEN(XLEN), .DEPTH(DEPTH), .INSTR_PER_FETCH(IPF)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
        .enq_pc_i(enq_pc_i), .enq_npc_i(enq_npc_i),
        .enq_slot_valid_i(enq_slot_valid_i), .enq_slot_idx_i(enq_slot_idx_i),
        .enq_slot_target_i(enq_slot_target_i),
        .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
        .deq_pc_o(deq_pc_o), .deq_npc_o(deq_npc_o),
        .deq_slot_valid_o(deq_slot_valid_o), .deq_slot_idx_o(deq_slot_idx_o),
        .deq_slot_target_o(deq_slot_target_o), .deq_ftq_idx_o(deq_ftq_idx_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        ev;
        logic        dr;
        logic        fl;
        logic [31:0] pc;
        logic        x_rdy;
        logic        x_dv;
        logic [3:0]  x_cnt;
        logic [31:0] x_pc;
        logic [2:0]  x_idx;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ev, input logic dr, input logic fl, input logic [31:0] pc,
                                input logic rdy, input logic dv, input logic [3:0] cnt,
                                input logic [31:0] xpc, input logic [2:0] idx);
        vec_t v;
        v.ev = ev; v.dr = dr; v.fl = fl; v.pc = pc;
        v.x_rdy = rdy; v.x_dv = dv; v.x_cnt = cnt; v.x_pc = xpc; v.x_idx = idx;
        return v;
    endfunction

    task automatic drive(input logic ev, input logic dr, input logic fl, input logic [31:0] pc);
        enq_valid_i = ev;
        deq_ready_i = dr;
        flush_i     = fl;
        enq_pc_i    = pc;
        enq_npc_i   = pc + 32'h10;
        enq_slot_valid_i  = 1'b0;
        enq_slot_idx_i    = 2'd0;
        enq_slot_target_i = '0;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // reset idle, then single enq (pc 0x8000_0000) and dequeue
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h8000_0000, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,         1, 1, 1, 32'h8000_0000, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0,         0, 0, 0, 32'h0, 1));
        // fill eight entries from a flushed (zero) pointer
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 0, 0, 32'h100 + 32'(16 * k), 1, k > 0, 4'(k),
                              k > 0 ? 32'h100 : 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h180, 0, 1, 8, 32'h100, 0));
        // full with deq: head leaves, held enq accepted next cycle
        vecs.push_back(mk(1, 1, 0, 32'h180, 0, 1, 8, 32'h100, 0));
        vecs.push_back(mk(1, 0, 0, 32'h180, 1, 1, 7, 32'h110, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 1, 8, 32'h110, 1));
        // drain: 0x180 must appear last at storage index 0
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 1, 0, 32'h0, k > 0, 1, 4'(8 - k),
                              k < 7 ? 32'h110 + 32'(16 * k) : 32'h180, 3'((k + 1) % 8)));
        // five entries then flush with a dropped enq
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 0, 0, 32'h200 + 32'(16 * k), 1, k > 0, 4'(k),
                              k > 0 ? 32'h200 : 32'h0, 1));
        vecs.push_back(mk(1, 0, 1, 32'hdead_0000, 0, 0, 5, 32'h200, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h300, 1, 0, 0, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,   1, 1, 1, 32'h300, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 0, 32'h0, 1));

        #12 rst_ni = 1'b1;
        @(posedge clk_i); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].ev, vecs[i].dr, vecs[i].fl, vecs[i].pc);
            @(negedge clk_i);
            check($sformatf("v%0d enq_ready", i), 64'(enq_ready_o), 64'(vecs[i].x_rdy));
            check($sformatf("v%0d deq_valid", i), 64'(deq_valid_o), 64'(vecs[i].x_dv));
            check($sformatf("v%0d count", i), 64'(count_o), 64'(vecs[i].x_cnt));
            check($sformatf("v%0d ftq_idx", i), 64'(deq_ftq_idx_o), 64'(vecs[i].x_idx));
            if (vecs[i].x_dv || vecs[i].x_cnt == 0)
                check($sformatf("v%0d deq_pc", i), 64'(deq_pc_o), 64'(vecs[i].x_pc));
            if (vecs[i].x_dv)
                check($sformatf("v%0d deq_npc", i), 64'(deq_npc_o), 64'(vecs[i].x_pc + 32'h10));
            @(posedge clk_i); #1;
        end

        // streaming: deq sequence equals enq sequence one cycle late, count stays 1
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h1000 + 32'(16 * i));
            @(negedge clk_i);
            check($sformatf("s%0d enq_ready", i), 64'(enq_ready_o), 64'(1));
            check($sformatf("s%0d deq_valid", i), 64'(deq_valid_o), 64'(i > 0));
            check($sformatf("s%0d count", i), 64'(count_o), 64'(i > 0 ? 1 : 0));
            if (i > 0)
                check($sformatf("s%0d deq_pc", i), 64'(deq_pc_o), 64'(32'h1000 + 32'(16 * (i - 1))));
            @(posedge clk_i); #1;
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk_i);
        check("stream last pc", 64'(deq_pc_o), 64'(32'h1000 + 32'(16 * 19)));
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_i);
        check("stream drained count", 64'(count_o), 64'(0));
        check("stream drained valid", 64'(deq_valid_o), 64'(0));
        @(posedge clk_i); #1;

        // taken-slot payload held through a 3-cycle IFU stall
        drive(1'b1, 1'b0, 1'b0, 32'h8000_2000);
        enq_slot_valid_i  = 1'b1;
        enq_slot_idx_i    = 2'd2;
        enq_slot_target_i = 32'h8000_1000;
        @(posedge clk_i); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check($sformatf("t%0d deq_valid", i), 64'(deq_valid_o), 64'(1));
            check($sformatf("t%0d slot_valid", i), 64'(deq_slot_valid_o), 64'(1));
            check($sformatf("t%0d slot_idx", i), 64'(deq_slot_idx_o), 64'(2));
            check($sformatf("t%0d slot_target", i), 64'(deq_slot_target_o), 64'(32'h8000_1000));
            check($sformatf("t%0d pc", i), 64'(deq_pc_o), 64'(32'h8000_2000));
            @(posedge clk_i); #1;
        end
        // asynchronous reset mid-stall takes effect without a clock edge
        #1 rst_ni = 1'b0;
        #1;
        check("rst deq_valid", 64'(deq_valid_o), 64'(0));
        check("rst count", 64'(count_o), 64'(0));
        check("rst enq_ready", 64'(enq_ready_o), 64'(1));
        check("rst slot_target", 64'(deq_slot_target_o), 64'(0));
        check("rst pc", 64'(deq_pc_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("post rst count", 64'(count_o), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
